// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared constants, state encoding and helpers for pc_branch_unit
package pc_branch_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pc_branch_unit_if.sv
// rtl/pc_branch_unit_if.sv - PC stage bus: ALU flags/targets in, PC/trap handshake out
// BRANCH_COUNT_EN adds the br_total/br_taken counter outputs.
interface pc_branch_unit_if;
  logic        en;
  logic        branch;
  logic        jal;
  logic        jalr;
  logic [2:0]  funct3;
  logic        zf;
  logic        sf;
  logic        cf;
  logic        a_msb;
  logic        b_msb;
  logic [31:0] imm;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        taken;
  logic        trap_req;
  logic        trap_ack;
  logic [31:0] epc;
`ifdef BRANCH_COUNT_EN
  logic [31:0] br_total;
  logic [31:0] br_taken;
`endif

  modport master (
`ifdef BRANCH_COUNT_EN
    input  br_total, br_taken,
`endif
    output en, branch, jal, jalr, funct3, zf, sf, cf, a_msb, b_msb,
    output imm, alu_result, trap_ack,
    input  pc, pc_plus4, next_pc, taken, trap_req, epc
  );

  modport slave (
`ifdef BRANCH_COUNT_EN
    output br_total, br_taken,
`endif
    input  en, branch, jal, jalr, funct3, zf, sf, cf, a_msb, b_msb,
    input  imm, alu_result, trap_ack,
    output pc, pc_plus4, next_pc, taken, trap_req, epc
  );
endinterface

// File: rtl/pc_branch_unit_branch_cond.sv
// rtl/pc_branch_unit_branch_cond.sv - combinational RV32I branch condition from ALU SUB flags
module pc_branch_unit_branch_cond
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zf,
  input  logic       sf,
  input  logic       cf,
  input  logic       a_msb,
  input  logic       b_msb,
  output logic       cond
);

  logic lt_s;
  logic lt_u;

  // Differing operand signs decide signed order directly; otherwise SUB cannot overflow.
  assign lt_s = (a_msb != b_msb) ? a_msb : sf;
  assign lt_u = cf;

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zf;
      F3_BNE:  cond = !zf;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC register, branch/jump resolution and misaligned-target trap
// BRANCH_COUNT_EN enables saturating branch total/taken counters.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic              clk,
  input  logic              rst,
  pc_branch_unit_if.slave   bus
);

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] next_pc;
  logic        cond;
  logic        taken;
  logic        misalign;

  pc_branch_unit_branch_cond u_cond (
    .funct3 (bus.funct3),
    .zf     (bus.zf),
    .sf     (bus.sf),
    .cf     (bus.cf),
    .a_msb  (bus.a_msb),
    .b_msb  (bus.b_msb),
    .cond   (cond)
  );

  assign pc_plus4 = pc_q + 32'd4;
  assign target   = bus.jalr ? (bus.alu_result & ~32'h1) : (pc_q + bus.imm);
  assign taken    = bus.jalr | bus.jal | (bus.branch & cond);
  assign next_pc  = taken ? target : pc_plus4;
  assign misalign = taken & target[1];

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    epc_d   = epc_q;
    case (state)
      RUN: begin
        if (bus.en) begin
          if (misalign) begin
            epc_d   = pc_q;
            state_d = TRAP;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      TRAP: begin
        if (bus.trap_ack) begin
          pc_d    = TRAP_VEC;
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc_q  <= RESET_PC;
      epc_q <= 32'h0;
    end else begin
      state <= state_d;
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.next_pc  = next_pc;
  assign bus.taken    = taken;
  assign bus.trap_req = (state == TRAP);
  assign bus.epc      = epc_q;

`ifdef BRANCH_COUNT_EN
  logic [31:0] br_total_q;
  logic [31:0] br_taken_q;
  logic        count_en;

  // Misaligned branches trap instead of retiring, so they are not counted.
  assign count_en = (state == RUN) & bus.en & bus.branch & !misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_total_q <= 32'h0;
      br_taken_q <= 32'h0;
    end else if (count_en) begin
      br_total_q <= sat_inc(br_total_q);
      if (cond) begin
        br_taken_q <= sat_inc(br_taken_q);
      end
    end
  end

  assign bus.br_total = br_total_q;
  assign bus.br_taken = br_taken_q;
`endif

endmodule
